bresenham_line_drawer: RTL and testbench



---
 rtl/bresenham_line_drawer.sv | 140 ++++++++++++++
 tb/tb_bresenham_line_drawer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bresenham_line_drawer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bresenham_line_drawer                                      |
// | Description : Integer Bresenham line rasteriser. Latches one line's      |
// |               endpoints on a draw_en request and walks the line. It      |
// |               emits one pixel per accepted valid/ready beat, then pulses |
// |               draw_done for one cycle.                                   |
// | Ports       : clk, n_rst (async, active-low)                             |
// |               draw_en, x0, y0, x1, y1     - line request and endpoints    |
// |               pixel_ready / pixel_valid   - pixel handshake              |
// |               pixel_x, pixel_y            - current pixel (registered)   |
// |               draw_done                   - one-cycle completion pulse   |
// |               busy                        - high outside IDLE            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bresenham_line_drawer (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       draw_en,
   input  logic [7:0] x0,
   input  logic [7:0] y0,
   input  logic [7:0] x1,
   input  logic [7:0] y1,
   input  logic       pixel_ready,
   output logic       pixel_valid,
   output logic [7:0] pixel_x,
   output logic [7:0] pixel_y,
   output logic       draw_done,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      STEP  = 3'd2,
      DONE  = 3'd3,
      REARM = 3'd4
   } state_t;

   state_t             r_state;
   logic [7:0]         r_x0, r_y0, r_x1, r_y1;
   logic signed [11:0] r_dx;     // +|x1-x0|
   logic signed [11:0] r_dy;     // -|y1-y0|
   logic signed [11:0] r_err;
   logic               r_sx_neg; // step direction: 1 = decrement
   logic               r_sy_neg;

   logic [7:0]         w_abs_dx, w_abs_dy;
   logic signed [11:0] w_e2, w_err_next;
   logic               w_step_x, w_step_y, w_at_end, w_beat;
   logic [7:0]         w_next_x, w_next_y;

   assign w_abs_dx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
   assign w_abs_dy = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

   // Both axis decisions use the pre-update error term.
   assign w_e2       = r_err <<< 1;
   assign w_step_x   = (w_e2 >= r_dy);
   assign w_step_y   = (w_e2 <= r_dx);
   assign w_err_next = r_err + (w_step_x ? r_dy : 12'sd0) + (w_step_y ? r_dx : 12'sd0);

   assign w_next_x = !w_step_x ? pixel_x : (r_sx_neg ? pixel_x - 8'd1 : pixel_x + 8'd1);
   assign w_next_y = !w_step_y ? pixel_y : (r_sy_neg ? pixel_y - 8'd1 : pixel_y + 8'd1);

   // The displayed pixel register doubles as the walk cursor.
   assign w_at_end = (pixel_x == r_x1) && (pixel_y == r_y1);
   assign w_beat   = pixel_valid && pixel_ready;

   assign draw_done = (r_state == DONE);
   assign busy      = (r_state != IDLE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= IDLE;
         r_x0        <= 8'd0;
         r_y0        <= 8'd0;
         r_x1        <= 8'd0;
         r_y1        <= 8'd0;
         r_dx        <= 12'sd0;
         r_dy        <= 12'sd0;
         r_err       <= 12'sd0;
         r_sx_neg    <= 1'b0;
         r_sy_neg    <= 1'b0;
         pixel_valid <= 1'b0;
         pixel_x     <= 8'd0;
         pixel_y     <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (draw_en) begin
                  r_x0    <= x0;
                  r_y0    <= y0;
                  r_x1    <= x1;
                  r_y1    <= y1;
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               r_dx        <= $signed({4'd0, w_abs_dx});
               r_dy        <= -$signed({4'd0, w_abs_dy});
               r_err       <= $signed({4'd0, w_abs_dx}) - $signed({4'd0, w_abs_dy});
               r_sx_neg    <= !(r_x0 < r_x1);
               r_sy_neg    <= !(r_y0 < r_y1);
               pixel_x     <= r_x0;
               pixel_y     <= r_y0;
               pixel_valid <= 1'b1;
               r_state     <= STEP;
            end
            STEP: begin
               // Without a beat everything holds, keeping the pixel stable.
               if (w_beat) begin
                  if (w_at_end) begin
                     pixel_valid <= 1'b0;
                     r_state     <= DONE;
                  end else begin
                     r_err   <= w_err_next;
                     pixel_x <= w_next_x;
                     pixel_y <= w_next_y;
                  end
               end
            end
            DONE: begin
               r_state <= draw_en ? REARM : IDLE;
            end
            REARM: begin
               // A request still held from the finished line must not restart it.
               if (!draw_en) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               pixel_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bresenham_line_drawer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bresenham_line_drawer                                   |
// | Description : Self-checking bench for bresenham_line_drawer. Directed    |
// |               lines plus random lines against an integer line model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bresenham_line_drawer;

   logic       clk;
   logic       n_rst;
   logic       draw_en;
   logic [7:0] x0, y0, x1, y1;
   logic       pixel_ready;
   logic       pixel_valid;
   logic [7:0] pixel_x, pixel_y;
   logic       draw_done;
   logic       busy;

   int total;
   int bad;
   int ex_q[$];
   int ey_q[$];

   bresenham_line_drawer dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .draw_en     (draw_en),
      .x0          (x0),
      .y0          (y0),
      .x1          (x1),
      .y1          (y1),
      .pixel_ready (pixel_ready),
      .pixel_valid (pixel_valid),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .draw_done   (draw_done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference line with unbounded integers: the classic error-term walk.
   function automatic void build_model(input int ax0, input int ay0, input int ax1, input int ay1);
      int dx, dy, sx, sy, err, e2, x, y;
      ex_q.delete();
      ey_q.delete();
      dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
      sx  = (ax0 < ax1) ? 1 : -1;
      sy  = (ay0 < ay1) ? 1 : -1;
      err = dx + dy;
      x   = ax0;
      y   = ay0;
      for (int k = 0; k < 600; k++) begin
         ex_q.push_back(x);
         ey_q.push_back(y);
         if (x == ax1 && y == ay1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endfunction

   // mode 0: always ready, 1: random ready, 2: 3 stall cycles on second beat
   task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int mode, input int hold_after);
      int got, cyc, first_cyc, last_beat_cyc, done_cyc, stalls, n_exp, adx, ady;
      logic prev_valid, prev_ready;
      logic [7:0] prev_x, prev_y;
      bit done_seen;
      build_model(ax0, ay0, ax1, ay1);
      adx   = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      ady   = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
      n_exp = ((adx > ady) ? adx : ady) + 1;
      got = 0; cyc = 0; first_cyc = -1; last_beat_cyc = -1; done_cyc = -1; stalls = 0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_x = 8'd0; prev_y = 8'd0;
      done_seen = 1'b0;

      @(posedge clk); #1;
      x0 = ax0[7:0]; y0 = ay0[7:0]; x1 = ax1[7:0]; y1 = ay1[7:0];
      draw_en = 1'b1;
      pixel_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;

      while (!done_seen && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 2) chk("busy_in_setup", busy, 1);
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", pixel_valid, 1);
            chk("hold_x", pixel_x, prev_x);
            chk("hold_y", pixel_y, prev_y);
         end
         if (pixel_valid) begin
            if (first_cyc < 0) begin
               first_cyc = cyc;
               chk("first_latency", first_cyc, 3);
            end
            if (pixel_ready) begin
               if (got < ex_q.size()) begin
                  chk("pix_x", pixel_x, ex_q[got]);
                  chk("pix_y", pixel_y, ey_q[got]);
               end
               got++;
               last_beat_cyc = cyc;
            end
         end
         if (draw_done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
         prev_valid = pixel_valid;
         prev_ready = pixel_ready;
         prev_x     = pixel_x;
         prev_y     = pixel_y;
         if (!done_seen) begin
            @(posedge clk); #1;
            // Endpoint changes after accept must not disturb the line.
            x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
            if (mode == 1) pixel_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && got == 1 && stalls < 3) begin
               pixel_ready = 1'b0;
               stalls++;
            end else pixel_ready = 1'b1;
         end
      end

      chk("done_seen", done_seen, 1);
      chk("pixel_count", got, n_exp);
      chk("done_after_last", done_cyc, last_beat_cyc + 1);
      if (mode == 2) chk("stall_cycles", stalls, 3);

      // Controller holds draw_en for hold_after cycles, then drops it.
      for (int h = 0; h <= hold_after; h++) begin
         @(posedge clk); #1;
         if (h == hold_after) draw_en = 1'b0;
         @(negedge clk);
         chk("rearm_busy", busy, 1);
         chk("done_single", draw_done, 0);
         chk("rearm_no_pixel", pixel_valid, 0);
      end
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", draw_done, 0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      n_rst = 1'b0;
      draw_en = 1'b0;
      pixel_ready = 1'b0;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0;

      #3;
      chk("rst_valid", pixel_valid, 0);
      chk("rst_x", pixel_x, 0);
      chk("rst_y", pixel_y, 0);
      chk("rst_done", draw_done, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;

      // Horizontal line
      run_line(0, 0, 3, 0, 0, 0);
      // Steep line, both axes decreasing
      run_line(5, 5, 3, 0, 0, 0);
      // Backpressure on the second beat
      run_line(10, 10, 13, 12, 2, 0);
      // Degenerate line with draw_en held after completion
      run_line(7, 7, 7, 7, 0, 5);
      // Full-range diagonal
      run_line(0, 0, 255, 255, 0, 0);

      // Reset in the middle of a line
      @(posedge clk); #1;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd0;
      draw_en = 1'b1;
      pixel_ready = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_abort_valid", pixel_valid, 1);
      chk("pre_abort_x", pixel_x, 2);
      n_rst = 1'b0;
      #1;
      chk("abort_valid", pixel_valid, 0);
      chk("abort_x", pixel_x, 0);
      chk("abort_y", pixel_y, 0);
      chk("abort_done", draw_done, 0);
      chk("abort_busy", busy, 0);
      draw_en = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_done", draw_done, 0);
      end
      @(posedge clk); #1 n_rst = 1'b1;
      run_line(1, 1, 2, 1, 0, 0);

      // Random lines with random backpressure
      for (int i = 0; i < 6; i++) begin
         run_line($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255), 1, $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
